// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
//   Shared widths, limits and helpers for the wallclock timekeeping core.
//   Ports: none (package).
//   Contents:
//     HOUR_W / MIN_W / SEC_W      binary widths of the time-of-day fields
//     MAX_HOUR / MAX_MIN / MAX_SEC last legal value of each field
//     BCD_IN_W                    width of the 0..99 input of bin_to_bcd2
//     tod_t                       packed hh:mm:ss time-of-day record
//     hour_to_12h()               24h hour -> 12h display hour
// ---------------------------------------------------------------------------
package clock_pkg;

   localparam int HOUR_W   = 5;
   localparam int MIN_W    = 6;
   localparam int SEC_W    = 6;
   localparam int BCD_IN_W = 7;

   localparam logic [HOUR_W-1:0] MAX_HOUR  = HOUR_W'(23);
   localparam logic [MIN_W-1:0]  MAX_MIN   = MIN_W'(59);
   localparam logic [SEC_W-1:0]  MAX_SEC   = SEC_W'(59);
   localparam logic [HOUR_W-1:0] NOON_HOUR = HOUR_W'(12);

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  minute;
      logic [SEC_W-1:0]  second;
   } tod_t;

   // Midnight shows as 12, afternoon hours fold down by twelve.
   function automatic logic [HOUR_W-1:0] hour_to_12h(input logic [HOUR_W-1:0] hour);
      if (hour == '0)
         return NOON_HOUR;
      else if (hour > NOON_HOUR)
         return hour - NOON_HOUR;
      else
         return hour;
   endfunction

endpackage

// File: rtl/timekeeper_core_if.sv
// ---------------------------------------------------------------------------
// timekeeper_core_if
//   Control and display bundle of the wallclock core.
//   master modport (board / controller side):
//     drives  RUN, MODE_12H, INC_MIN, INC_HOUR, LOAD, LOAD_HOUR, LOAD_MIN,
//             ALARM_EN, ALARM_HOUR, ALARM_MIN
//     samples HOURS_T, HOURS_U, MINS_T, MINS_U, SECS, PM,
//             SEC_TICK, ALARM_HIT, LOAD_ERR
//   slave modport (timekeeper_core side): the mirror image.
// ---------------------------------------------------------------------------
interface timekeeper_core_if;
   import clock_pkg::*;

   // controls
   logic              RUN;
   logic              MODE_12H;
   logic              INC_MIN;
   logic              INC_HOUR;
   logic              LOAD;
   logic [HOUR_W-1:0] LOAD_HOUR;
   logic [MIN_W-1:0]  LOAD_MIN;
   logic              ALARM_EN;
   logic [HOUR_W-1:0] ALARM_HOUR;
   logic [MIN_W-1:0]  ALARM_MIN;

   // display and status
   logic [3:0]        HOURS_T;
   logic [3:0]        HOURS_U;
   logic [3:0]        MINS_T;
   logic [3:0]        MINS_U;
   logic [SEC_W-1:0]  SECS;
   logic              PM;
   logic              SEC_TICK;
   logic              ALARM_HIT;
   logic              LOAD_ERR;

   modport master (
      output RUN, MODE_12H, INC_MIN, INC_HOUR, LOAD, LOAD_HOUR, LOAD_MIN,
             ALARM_EN, ALARM_HOUR, ALARM_MIN,
      input  HOURS_T, HOURS_U, MINS_T, MINS_U, SECS, PM,
             SEC_TICK, ALARM_HIT, LOAD_ERR
   );

   modport slave (
      input  RUN, MODE_12H, INC_MIN, INC_HOUR, LOAD, LOAD_HOUR, LOAD_MIN,
             ALARM_EN, ALARM_HOUR, ALARM_MIN,
      output HOURS_T, HOURS_U, MINS_T, MINS_U, SECS, PM,
             SEC_TICK, ALARM_HIT, LOAD_ERR
   );

endinterface

// File: rtl/bin_to_bcd2.sv
// ---------------------------------------------------------------------------
// bin_to_bcd2
//   Combinational two-digit binary to BCD conversion for values 0..99.
//   Ports:
//     i_bin    in   7  binary value 0..99 (larger values saturate tens at 9)
//     o_tens   out  4  BCD tens digit
//     o_units  out  4  BCD units digit
// ---------------------------------------------------------------------------
module bin_to_bcd2
   import clock_pkg::*;
(
   input  logic [BCD_IN_W-1:0] i_bin,
   output logic [3:0]          o_tens,
   output logic [3:0]          o_units
);

   logic [BCD_IN_W-1:0] w_tens_x10;

   // Threshold ladder instead of a divider: the last threshold passed gives
   // the tens digit, and the remainder is the units digit.
   // NOTE: every combinational output gets a default before the branches so
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      o_tens     = 4'd0;
      w_tens_x10 = '0;
      for (int k = 1; k <= 9; k++) begin
         if (i_bin >= BCD_IN_W'(10 * k)) begin
            o_tens     = 4'(k);
            w_tens_x10 = BCD_IN_W'(10 * k);
         end
      end
      o_units = 4'(i_bin - w_tens_x10);
   end

endmodule

// File: rtl/timekeeper_core.sv
// ---------------------------------------------------------------------------
// timekeeper_core
//   24h/12h wallclock: prescaler, hh:mm:ss state, run/pause, direct load,
//   debounced button increments, 12h display map and alarm compare.
//   Parameters:
//     TICK_DIV  clock cycles per second (2..2^DIV_W)
//     DIV_W     prescaler width
//   Ports:
//     CLK100MHZ  in  system clock
//     RESET_BTN  in  asynchronous active-high reset
//     bus        timekeeper_core_if.slave
//                  controls : RUN, MODE_12H, INC_MIN, INC_HOUR, LOAD,
//                             LOAD_HOUR, LOAD_MIN, ALARM_EN, ALARM_HOUR, ALARM_MIN
//                  display  : HOURS_T/U, MINS_T/U (BCD), SECS (binary), PM
//                  pulses   : SEC_TICK, ALARM_HIT, LOAD_ERR (registered)
// ---------------------------------------------------------------------------
module timekeeper_core
   import clock_pkg::*;
#(
   parameter int TICK_DIV = 100000000,
   parameter int DIV_W    = 27
) (
   input  logic             CLK100MHZ,
   input  logic             RESET_BTN,
   timekeeper_core_if.slave bus
);

   localparam logic [DIV_W-1:0] LP_DIV_LAST = DIV_W'(TICK_DIV - 1);

   // state
   tod_t             r_time;
   logic [DIV_W-1:0] r_div;
   logic             r_min_prev;
   logic             r_hour_prev;
   logic             r_pend_min;
   logic             r_pend_hour;
   logic             r_sec_tick;
   logic             r_alarm_hit;
   logic             r_load_err;

   // combinational helpers
   logic              w_min_rise;
   logic              w_hour_rise;
   logic              w_load_ok;
   logic              w_tick;
   logic              w_alarm_valid;
   logic              w_alarm_match;
   tod_t              w_time_adv;
   tod_t              w_time_btn;
   logic [HOUR_W-1:0] w_disp_hour;

   assign w_min_rise  = bus.INC_MIN  & ~r_min_prev;
   assign w_hour_rise = bus.INC_HOUR & ~r_hour_prev;

   assign w_load_ok = bus.LOAD && (bus.LOAD_HOUR <= MAX_HOUR) && (bus.LOAD_MIN <= MAX_MIN);

   // Tick qualifies only while running; a LOAD on the same edge discards it.
   assign w_tick = bus.RUN && (r_div == LP_DIV_LAST);

   // One-second advance with all carries resolved in a single edge.
   always_comb begin
      w_time_adv = r_time;
      if (r_time.second == MAX_SEC) begin
         w_time_adv.second = '0;
         if (r_time.minute == MAX_MIN) begin
            w_time_adv.minute = '0;
            w_time_adv.hour   = (r_time.hour == MAX_HOUR) ? '0 : r_time.hour + 1'b1;
         end else begin
            w_time_adv.minute = r_time.minute + 1'b1;
         end
      end else begin
         w_time_adv.second = r_time.second + 1'b1;
      end
   end

   // Button increments wrap within their own field: no carry between fields.
   always_comb begin
      w_time_btn = r_time;
      if (r_pend_min)
         w_time_btn.minute = (r_time.minute == MAX_MIN) ? '0 : r_time.minute + 1'b1;
      if (r_pend_hour)
         w_time_btn.hour = (r_time.hour == MAX_HOUR) ? '0 : r_time.hour + 1'b1;
   end

   // An out-of-range alarm setting is rejected here rather than relying on
   // field widths, so e.g. hh:60 can never alias onto (hh+1):00.
   assign w_alarm_valid = (bus.ALARM_HOUR <= MAX_HOUR) && (bus.ALARM_MIN <= MAX_MIN);
   assign w_alarm_match = bus.ALARM_EN && w_alarm_valid &&
                          (w_time_adv.hour   == bus.ALARM_HOUR) &&
                          (w_time_adv.minute == bus.ALARM_MIN)  &&
                          (w_time_adv.second == '0);

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK100MHZ or posedge RESET_BTN) begin
      if (RESET_BTN) begin
         r_time      <= '0;
         r_div       <= '0;
         r_min_prev  <= 1'b0;
         r_hour_prev <= 1'b0;
         r_pend_min  <= 1'b0;
         r_pend_hour <= 1'b0;
         r_sec_tick  <= 1'b0;
         r_alarm_hit <= 1'b0;
         r_load_err  <= 1'b0;
      end else begin
         r_min_prev  <= bus.INC_MIN;
         r_hour_prev <= bus.INC_HOUR;
         r_sec_tick  <= w_tick && !bus.LOAD;
         r_alarm_hit <= w_tick && !bus.LOAD && w_alarm_match;
         r_load_err  <= bus.LOAD && !w_load_ok;

         if (w_load_ok) begin
            // Accepted load: seconds and prescaler restart, queued presses dropped.
            r_time.hour   <= bus.LOAD_HOUR;
            r_time.minute <= bus.LOAD_MIN;
            r_time.second <= '0;
            r_div         <= '0;
            r_pend_min    <= 1'b0;
            r_pend_hour   <= 1'b0;
         end else if (bus.LOAD) begin
            // Rejected load freezes the clock for this edge; presses still queue.
            r_pend_min  <= r_pend_min  | w_min_rise;
            r_pend_hour <= r_pend_hour | w_hour_rise;
         end else if (w_tick) begin
            // Tick owns this edge; queued presses wait one more cycle.
            r_time      <= w_time_adv;
            r_div       <= '0;
            r_pend_min  <= r_pend_min  | w_min_rise;
            r_pend_hour <= r_pend_hour | w_hour_rise;
         end else begin
            if (bus.RUN)
               r_div <= r_div + 1'b1;
            r_time      <= w_time_btn;
            r_pend_min  <= w_min_rise;
            r_pend_hour <= w_hour_rise;
         end
      end
   end

   // Display path is purely combinational from the state registers.
   assign w_disp_hour = bus.MODE_12H ? hour_to_12h(r_time.hour) : r_time.hour;

   bin_to_bcd2 u_hour_bcd (
      .i_bin   (BCD_IN_W'(w_disp_hour)),
      .o_tens  (bus.HOURS_T),
      .o_units (bus.HOURS_U)
   );

   bin_to_bcd2 u_min_bcd (
      .i_bin   (BCD_IN_W'(r_time.minute)),
      .o_tens  (bus.MINS_T),
      .o_units (bus.MINS_U)
   );

   assign bus.SECS      = r_time.second;
   assign bus.PM        = (r_time.hour >= NOON_HOUR);
   assign bus.SEC_TICK  = r_sec_tick;
   assign bus.ALARM_HIT = r_alarm_hit;
   assign bus.LOAD_ERR  = r_load_err;

endmodule

// File: tb/tb_timekeeper_core.sv
// ---------------------------------------------------------------------------
// tb_timekeeper_core
//   Self-checking bench for timekeeper_core with TICK_DIV = 4. The reference
//   keeps time as seconds-of-day; every pulse the DUT should produce is queued
//   with its edge number and popped by an independent monitor.
// ---------------------------------------------------------------------------
module tb_timekeeper_core;
   import clock_pkg::*;

   localparam int TICK_DIV = 4;
   localparam int DAY_SECS = 24 * 3600;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   timekeeper_core_if tk_bus ();

   timekeeper_core #(.TICK_DIV(TICK_DIV), .DIV_W(3)) dut (
      .CLK100MHZ (clk),
      .RESET_BTN (rst),
      .bus       (tk_bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int edge_id; int t; bit alarm; } tick_rec_t;
   typedef struct { int edge_id; int t; } err_rec_t;

   tick_rec_t tick_q[$];
   err_rec_t  err_q[$];

   int m_t;            // seconds since midnight
   int m_div;          // cycles elapsed in the current second
   bit m_pend_min, m_pend_hour, m_prev_min, m_prev_hour;
   int edge_no = 0;
   bit mon_en = 1'b0;
   int alarm_seen = 0;

   function automatic int disp_hour(input int t, input bit m12);
      int h = t / 3600;
      if (!m12) return h;
      if (h == 0) return 12;
      if (h > 12) return h - 12;
      return h;
   endfunction

   task automatic model_reset();
      m_t = 0; m_div = 0;
      m_pend_min = 0; m_pend_hour = 0; m_prev_min = 0; m_prev_hour = 0;
      tick_q.delete(); err_q.delete();
   endtask

   // Applies one clock edge's worth of behaviour using the inputs as driven.
   task automatic model_edge();
      bit rm, rh, tick, alarm;
      int h, mi, s, at;
      rm = tk_bus.INC_MIN  && !m_prev_min;
      rh = tk_bus.INC_HOUR && !m_prev_hour;
      m_prev_min  = tk_bus.INC_MIN;
      m_prev_hour = tk_bus.INC_HOUR;
      tick = tk_bus.RUN && (m_div == TICK_DIV - 1);
      if (tk_bus.LOAD) begin
         if (tk_bus.LOAD_HOUR <= 23 && tk_bus.LOAD_MIN <= 59) begin
            m_t = tk_bus.LOAD_HOUR * 3600 + tk_bus.LOAD_MIN * 60;
            m_div = 0; m_pend_min = 0; m_pend_hour = 0;
         end else begin
            err_q.push_back('{edge_no, m_t});
            m_pend_min |= rm; m_pend_hour |= rh;
         end
      end else if (tick) begin
         m_div = 0;
         m_t = (m_t + 1) % DAY_SECS;
         at = tk_bus.ALARM_HOUR * 3600 + tk_bus.ALARM_MIN * 60;
         alarm = tk_bus.ALARM_EN && tk_bus.ALARM_HOUR <= 23 && tk_bus.ALARM_MIN <= 59 && (m_t == at);
         tick_q.push_back('{edge_no, m_t, alarm});
         m_pend_min |= rm; m_pend_hour |= rh;
      end else begin
         if (tk_bus.RUN) m_div++;
         h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
         if (m_pend_min)  mi = (mi + 1) % 60;
         if (m_pend_hour) h = (h + 1) % 24;
         m_t = h * 3600 + mi * 60 + s;
         m_pend_min = rm; m_pend_hour = rh;
      end
   endtask

   task automatic check_disp(input string tag, input int t);
      int dh = disp_hour(t, tk_bus.MODE_12H);
      check({tag, "_hours_t"}, int'(tk_bus.HOURS_T), dh / 10);
      check({tag, "_hours_u"}, int'(tk_bus.HOURS_U), dh % 10);
      check({tag, "_mins_t"},  int'(tk_bus.MINS_T), ((t / 60) % 60) / 10);
      check({tag, "_mins_u"},  int'(tk_bus.MINS_U), ((t / 60) % 60) % 10);
      check({tag, "_secs"},    int'(tk_bus.SECS),   t % 60);
      check({tag, "_pm"},      int'(tk_bus.PM),     int'(t >= 12 * 3600));
   endtask

   // ---------------- monitor ----------------
   tick_rec_t mon_tick;
   err_rec_t  mon_err;

   always @(negedge clk) begin
      if (mon_en) begin
         check_disp("disp", m_t);
         if (tk_bus.ALARM_HIT) alarm_seen++;
         if (tk_bus.SEC_TICK) begin
            if (tick_q.size() == 0) begin
               check("sec_tick_unexpected", 1, 0);
            end else begin
               mon_tick = tick_q.pop_front();
               check("sec_tick_edge", edge_no, mon_tick.edge_id);
               check("sec_tick_time", int'(tk_bus.SECS), mon_tick.t % 60);
               check("alarm_hit", int'(tk_bus.ALARM_HIT), int'(mon_tick.alarm));
            end
         end else begin
            check("alarm_without_tick", int'(tk_bus.ALARM_HIT), 0);
         end
         if (tk_bus.LOAD_ERR) begin
            if (err_q.size() == 0) begin
               check("load_err_unexpected", 1, 0);
            end else begin
               mon_err = err_q.pop_front();
               check("load_err_edge", edge_no, mon_err.edge_id);
               check("load_err_secs", int'(tk_bus.SECS), mon_err.t % 60);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      edge_no++;
      model_edge();
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load_time(input int h, input int mi);
      tk_bus.LOAD      = 1'b1;
      tk_bus.LOAD_HOUR = HOUR_W'(h);
      tk_bus.LOAD_MIN  = MIN_W'(mi);
      step();
      tk_bus.LOAD = 1'b0;
   endtask

   task automatic wait_div(input int target);
      for (int i = 0; i < 2 * TICK_DIV && m_div != target; i++) step();
   endtask

   // Asynchronous reset applied between clock edges.
   task automatic do_reset(input string tag);
      mon_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_disp(tag, 0);
      check({tag, "_sec_tick"},  int'(tk_bus.SEC_TICK), 0);
      check({tag, "_alarm_hit"}, int'(tk_bus.ALARM_HIT), 0);
      check({tag, "_load_err"},  int'(tk_bus.LOAD_ERR), 0);
      @(negedge clk);
      rst = 1'b0;
      #1 mon_en = 1'b1;
   endtask

   int a0;

   initial begin
      tk_bus.RUN = 1'b0; tk_bus.MODE_12H = 1'b0;
      tk_bus.INC_MIN = 1'b0; tk_bus.INC_HOUR = 1'b0;
      tk_bus.LOAD = 1'b0; tk_bus.LOAD_HOUR = '0; tk_bus.LOAD_MIN = '0;
      tk_bus.ALARM_EN = 1'b0; tk_bus.ALARM_HOUR = '0; tk_bus.ALARM_MIN = '0;
      model_reset();
      #12;
      do_reset("rst0");

      // 1: reset mid-count, then first second after four edges
      tk_bus.RUN = 1'b1;
      steps(6);
      do_reset("rst_mid");
      steps(3);
      check("t1_secs_before", int'(tk_bus.SECS), 0);
      step();
      check("t1_secs_after", int'(tk_bus.SECS), 1);
      check("t1_sec_tick", int'(tk_bus.SEC_TICK), 1);
      steps(8);

      // 2: 23:59 rolls to 00:00:00
      load_time(23, 59);
      check("t2_pm_before", int'(tk_bus.PM), 1);
      steps(60 * TICK_DIV);
      check("t2_hours_t", int'(tk_bus.HOURS_T), 0);
      check("t2_hours_u", int'(tk_bus.HOURS_U), 0);
      check("t2_mins_t",  int'(tk_bus.MINS_T), 0);
      check("t2_mins_u",  int'(tk_bus.MINS_U), 0);
      check("t2_secs",    int'(tk_bus.SECS), 0);
      check("t2_pm_after", int'(tk_bus.PM), 0);

      // 3: minute button without hour carry, and a press aligned with a tick
      load_time(10, 59);
      steps(30 * TICK_DIV);
      tk_bus.RUN = 1'b0;
      tk_bus.INC_MIN = 1'b1;
      steps(2);
      check("t3_hours_u", int'(tk_bus.HOURS_U), 0);
      check("t3_hours_t", int'(tk_bus.HOURS_T), 1);
      check("t3_mins_u",  int'(tk_bus.MINS_U), 0);
      check("t3_mins_t",  int'(tk_bus.MINS_T), 0);
      check("t3_secs",    int'(tk_bus.SECS), 30);
      tk_bus.INC_MIN = 1'b0;
      step();
      tk_bus.RUN = 1'b1;
      wait_div(TICK_DIV - 2);
      tk_bus.INC_MIN = 1'b1;
      step();
      step();
      check("t3_tick_edge", int'(tk_bus.SEC_TICK), 1);
      check("t3_min_held", int'(tk_bus.MINS_U), 0);
      step();
      check("t3_min_applied", int'(tk_bus.MINS_U), 1);
      tk_bus.INC_MIN = 1'b0;
      tk_bus.RUN = 1'b0;
      load_time(23, 5);
      tk_bus.INC_HOUR = 1'b1; tk_bus.INC_MIN = 1'b1;
      steps(2);
      check("t3_hour_wrap", int'(tk_bus.HOURS_U), 0);
      check("t3_both_min", int'(tk_bus.MINS_U), 6);
      tk_bus.INC_HOUR = 1'b0; tk_bus.INC_MIN = 1'b0;
      step();

      // 4: rejected loads, and a load on the tick edge
      load_time(24, 10);
      check("t4_load_err_h", int'(tk_bus.LOAD_ERR), 1);
      check("t4_kept_min", int'(tk_bus.MINS_U), 6);
      step();
      load_time(5, 60);
      check("t4_load_err_m", int'(tk_bus.LOAD_ERR), 1);
      tk_bus.RUN = 1'b1;
      wait_div(TICK_DIV - 1);
      load_time(5, 6);
      check("t4_tick_dropped", int'(tk_bus.SEC_TICK), 0);
      check("t4_secs_zero", int'(tk_bus.SECS), 0);
      check("t4_hour", int'(tk_bus.HOURS_U), 5);
      check("t4_min", int'(tk_bus.MINS_U), 6);

      // 5: 12h display map
      tk_bus.RUN = 1'b0;
      tk_bus.MODE_12H = 1'b1;
      load_time(0, 0);
      check("t5_h0_t", int'(tk_bus.HOURS_T), 1);
      check("t5_h0_u", int'(tk_bus.HOURS_U), 2);
      check("t5_h0_pm", int'(tk_bus.PM), 0);
      load_time(12, 0);
      check("t5_h12_u", int'(tk_bus.HOURS_U), 2);
      check("t5_h12_pm", int'(tk_bus.PM), 1);
      load_time(13, 0);
      check("t5_h13_t", int'(tk_bus.HOURS_T), 0);
      check("t5_h13_u", int'(tk_bus.HOURS_U), 1);
      check("t5_h13_pm", int'(tk_bus.PM), 1);
      do_reset("rst_12h");
      tk_bus.MODE_12H = 1'b0;

      // 6: alarm once while running, never while paused or out of range
      tk_bus.ALARM_EN = 1'b1; tk_bus.ALARM_HOUR = 5'd7; tk_bus.ALARM_MIN = 6'd30;
      load_time(7, 29);
      tk_bus.RUN = 1'b1;
      a0 = alarm_seen;
      steps(60 * TICK_DIV + 2);
      check("t6_alarm_once", alarm_seen - a0, 1);
      tk_bus.RUN = 1'b0;
      load_time(7, 29);
      a0 = alarm_seen;
      steps(60 * TICK_DIV + 2);
      check("t6_alarm_paused", alarm_seen - a0, 0);
      tk_bus.ALARM_HOUR = 5'd6; tk_bus.ALARM_MIN = 6'd60;
      load_time(6, 59);
      tk_bus.RUN = 1'b1;
      a0 = alarm_seen;
      steps(60 * TICK_DIV + 2);
      check("t6_alarm_out_of_range", alarm_seen - a0, 0);

      // random phase
      for (int i = 0; i < 3000; i++) begin
         tk_bus.RUN = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) tk_bus.MODE_12H = ~tk_bus.MODE_12H;
         if ($urandom_range(0, 7) == 0)  tk_bus.INC_MIN  = ~tk_bus.INC_MIN;
         if ($urandom_range(0, 9) == 0)  tk_bus.INC_HOUR = ~tk_bus.INC_HOUR;
         if ($urandom_range(0, 199) == 0) begin
            tk_bus.LOAD      = 1'b1;
            tk_bus.LOAD_HOUR = HOUR_W'($urandom_range(0, 26));
            tk_bus.LOAD_MIN  = MIN_W'($urandom_range(0, 62));
            tk_bus.ALARM_EN  = 1'($urandom_range(0, 1));
            tk_bus.ALARM_HOUR = tk_bus.LOAD_HOUR;
            tk_bus.ALARM_MIN  = MIN_W'((int'(tk_bus.LOAD_MIN) + 1) % 64);
         end
         step();
         tk_bus.LOAD = 1'b0;
      end
      steps(4);

      check("tick_q_drained", tick_q.size(), 0);
      check("err_q_drained", err_q.size(), 0);
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
